data_store_medium: RTL and testbench
====================================

# data_store_medium

Write-side counterpart of the data medium. Accepts one (x, y) training pair plus a sample address from the CPU and serializes it into a single-port BRAM as 2·PIECES consecutive BRAM_WIDTH-bit words. It uses the same address map and piece order that the read path consumes, so a pair written here reads back unchanged. It sits between the CPU/host loader and the data BRAM's write port, one instance per data BRAM.

## Interface

Parameters:
- ADDRS, 1024, number of (x, y) sample slots
- BRAM_WIDTH, 64, BRAM word width in bits
- PIECES, 16, BRAM words per x (and per y); X_WIDTH = PIECES·BRAM_WIDTH
- Derived: ADDR_SIZE = $clog2(ADDRS); BRAM_ADDR_SIZE = $clog2(ADDRS·PIECES·2)

Ports:
- clk_in, input, 1, single clock
- rst_in, input, 1, reset: asynchronous and active-low
- addr_in, input, ADDR_SIZE, sample slot to write
- x_in, input, X_WIDTH, x data
- y_in, input, X_WIDTH, y data
- valid_in, input, 1, request valid
- ready_out, output, 1, block can accept a request
- finished_out, output, 1, one-cycle pulse when a request completes
- error_out, output, 1, qualifies finished_out: request had addr_in ≥ ADDRS
- bram_dout, input, BRAM_WIDTH, unused; present for interface symmetry
- bram_addr, output, BRAM_ADDR_SIZE, BRAM address
- bram_we, output, 1, BRAM write enable
- bram_regce, output, 1, tied 0
- bram_din, output, BRAM_WIDTH, BRAM write data

## Operation

- States: IDLE, WRITE, DONE.
- IDLE: ready_out=1. When valid_in && ready_out, latch {x_in, y_in} into a 2·X_WIDTH buffer, latch addr_in, and clear piece counter k. If addr_in < ADDRS, go to WRITE; otherwise go to DONE with error set.
- WRITE: bram_we=1, bram_addr = addr·2·PIECES + k, and bram_din = bits [k·BRAM_WIDTH +: BRAM_WIDTH] of {x, y}. Pieces 0..PIECES-1 therefore hold y and pieces PIECES..2·PIECES-1 hold x. k increments each cycle. After k = 2·PIECES−1, go to DONE.
- DONE: finished_out=1 for one cycle, and error_out=1 if the address was rejected. Next state is IDLE.
- Address arithmetic is done at BRAM_ADDR_SIZE width with no truncation for legal addresses. k is $clog2(2·PIECES) bits wide and never wraps mid-request.
- Inputs are sampled only at the handshake. Changes to x_in, y_in or addr_in afterwards have no effect.
- Reset (asynchronous, active-low) forces IDLE. A write in progress is abandoned immediately: bram_we drops without waiting for a clock edge, and the slot is left partially written.

## Timing

- Reset values: ready_out=1, finished_out=0, error_out=0, bram_we=0, bram_regce=0, bram_addr=0, bram_din=0.
- All outputs are registered, or decoded from registered state only.
- Handshake accepted at edge 0 → writes on cycles 1..2·PIECES → finished_out high in cycle 2·PIECES+1 → ready_out=1 again in cycle 2·PIECES+2.
- Total latency is 2·PIECES+2 cycles per pair, so throughput is one pair per 2·PIECES+2 cycles.
- Rejected address: accept at edge 0, finished_out and error_out high in cycle 1, no bram_we.
- ready_out=0 in WRITE and DONE. A valid_in asserted then is held off and must stay asserted until accepted.

## Structure

- Shared package medium_pkg holds:
  - the ADDR_SIZE, BRAM_ADDR_SIZE and X_WIDTH derivation functions, shared with the read path;
  - the state enum (IDLE/WRITE/DONE);
  - a piece-address function base(addr)+k used by both reader and writer.
- One sub-module, piece_serializer: a loadable 2·X_WIDTH buffer with piece counter that emits BRAM_WIDTH slices and a last flag. The FSM and handshake stay in data_store_medium.

## Test plan

- Reset, then PIECES=2, BRAM_WIDTH=8, addr 3, y=16'hBBAA, x=16'hDDCC → bram_addr 12,13,14,15 with din AA,BB,CC,DD on four consecutive cycles; finished_out one cycle later; error_out=0.
- Round trip: write addr 0 and addr ADDRS−1 with random data, then read back through data_medium → x_out and y_out match exactly.
- valid_in held high for back-to-back requests → second request accepted only in the cycle ready_out returns to 1; no gap or overlap in the bram_we pattern other than the DONE and IDLE cycles.
- addr_in = ADDRS with ADDRS non-power-of-two (1000) → finished_out and error_out pulse in cycle 1; bram_we stays 0 throughout.
- rst_in driven low asynchronously mid-WRITE at k=1 → bram_we, ready_out and finished_out reach reset values before the next clock edge; the next request after reset completes normally.
- x_in/y_in changed every cycle during WRITE → BRAM contents equal the values latched at the handshake.

Source files
------------

// File: rtl/medium_pkg.sv
// rtl/medium_pkg.sv - shared widths, state encoding and piece addressing for the data medium
package medium_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  function automatic int addr_size(input int addrs);
    return $clog2(addrs);
  endfunction

  function automatic int bram_addr_size(input int addrs, input int pieces);
    return $clog2(addrs * pieces * 2);
  endfunction

  function automatic int x_width(input int pieces, input int bram_width);
    return pieces * bram_width;
  endfunction

  // Each slot owns 2*pieces consecutive words: y in the low half, x in the high half.
  function automatic int unsigned piece_addr(input int unsigned addr, input int unsigned pieces,
                                             input int unsigned k);
    return addr * 2 * pieces + k;
  endfunction

endpackage

// File: rtl/piece_serializer.sv
// rtl/piece_serializer.sv - loadable {x, y} buffer emitting BRAM-width pieces, low piece first
module piece_serializer #(
  parameter  int BRAM_WIDTH = 64,
  parameter  int PIECES     = 16,
  localparam int BUF_WIDTH  = 2 * PIECES * BRAM_WIDTH,
  localparam int K_SIZE     = $clog2(2 * PIECES)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load,
  input  logic [BUF_WIDTH-1:0]  data,
  input  logic                  advance,
  output logic [BRAM_WIDTH-1:0] piece,
  output logic [K_SIZE-1:0]     k,
  output logic                  last
);

  logic [BUF_WIDTH-1:0] data_q;

  // Shifting instead of indexing by k keeps the output a plain register slice;
  // the buffer drains to zero once every piece has been emitted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_q <= '0;
      k      <= '0;
    end else if (load) begin
      data_q <= data;
      k      <= '0;
    end else if (advance) begin
      data_q <= data_q >> BRAM_WIDTH;
      if (!last) k <= k + K_SIZE'(1);
    end
  end

  assign piece = data_q[BRAM_WIDTH-1:0];
  assign last  = (k == K_SIZE'(2 * PIECES - 1));

endmodule

// File: rtl/data_store_medium.sv
// rtl/data_store_medium.sv - serializes one (x, y) pair into 2*PIECES BRAM words at a sample slot
module data_store_medium
  import medium_pkg::*;
#(
  parameter  int ADDRS          = 1024,
  parameter  int BRAM_WIDTH     = 64,
  parameter  int PIECES         = 16,
  localparam int ADDR_SIZE      = addr_size(ADDRS),
  localparam int BRAM_ADDR_SIZE = bram_addr_size(ADDRS, PIECES),
  localparam int X_WIDTH        = x_width(PIECES, BRAM_WIDTH),
  localparam int K_SIZE         = $clog2(2 * PIECES)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [ADDR_SIZE-1:0]      addr_in,
  input  logic [X_WIDTH-1:0]        x_in,
  input  logic [X_WIDTH-1:0]        y_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic                      finished_out,
  output logic                      error_out,
  input  logic [BRAM_WIDTH-1:0]     bram_dout,
  output logic [BRAM_ADDR_SIZE-1:0] bram_addr,
  output logic                      bram_we,
  output logic                      bram_regce,
  output logic [BRAM_WIDTH-1:0]     bram_din
);

  state_t                state;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic                  err_q;
  logic                  accept;
  logic                  legal;
  logic [K_SIZE-1:0]     k;
  logic                  last;
  logic [BRAM_WIDTH-1:0] piece;
  logic                  unused_dout;

  assign accept = (state == IDLE) && valid_in;
  assign legal  = {1'b0, addr_in} < (ADDR_SIZE + 1)'(ADDRS);

  piece_serializer #(
    .BRAM_WIDTH(BRAM_WIDTH),
    .PIECES    (PIECES)
  ) u_serializer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (accept && legal),
    .data   ({x_in, y_in}),
    .advance(state == WRITE),
    .piece  (piece),
    .k      (k),
    .last   (last)
  );

  // A rejected slot leaves addr_q untouched so bram_addr does not move on an error.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            err_q <= !legal;
            if (legal) begin
              addr_q <= addr_in;
              state  <= WRITE;
            end else begin
              state <= DONE;
            end
          end
        end
        WRITE: if (last) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign ready_out    = (state == IDLE);
  assign finished_out = (state == DONE);
  assign error_out    = (state == DONE) && err_q;
  assign bram_we      = (state == WRITE);
  assign bram_regce   = 1'b0;
  assign bram_din     = piece;
  assign bram_addr    = BRAM_ADDR_SIZE'(piece_addr(32'(addr_q), 32'(PIECES), 32'(k)));

  assign unused_dout = ^bram_dout;

endmodule

// File: tb/tb_data_store_medium.sv
// tb/tb_data_store_medium.sv - scoreboard bench for data_store_medium
module tb_data_store_medium;

  localparam int ADDRS  = 1000;
  localparam int BW     = 8;
  localparam int PIECES = 2;
  localparam int XW     = PIECES * BW;
  localparam int AW     = $clog2(ADDRS);
  localparam int BAW    = $clog2(ADDRS * PIECES * 2);

  typedef struct {
    logic           done;
    logic           err;
    logic [BAW-1:0] addr;
    logic [BW-1:0]  din;
    int             cyc;
  } exp_t;

  logic           clk_in = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  addr_in = '0;
  logic [XW-1:0]  x_in = '0;
  logic [XW-1:0]  y_in = '0;
  logic           valid_in = 1'b0;
  logic [BW-1:0]  bram_dout = '0;
  logic           ready_out, finished_out, error_out, bram_we, bram_regce;
  logic [BAW-1:0] bram_addr;
  logic [BW-1:0]  bram_din;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_until = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [BW-1:0] mem [0:(1<<BAW)-1];

  data_store_medium #(
    .ADDRS     (ADDRS),
    .BRAM_WIDTH(BW),
    .PIECES    (PIECES)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_n),
    .addr_in     (addr_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .finished_out(finished_out),
    .error_out   (error_out),
    .bram_dout   (bram_dout),
    .bram_addr   (bram_addr),
    .bram_we     (bram_we),
    .bram_regce  (bram_regce),
    .bram_din    (bram_din)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // Inputs churn whenever no request is offered, so only handshake-time values may land in BRAM.
  always begin
    @(posedge clk_in);
    #2;
    if (!valid_in) begin
      x_in    = 16'($urandom);
      y_in    = 16'($urandom);
      addr_in = 10'($urandom);
    end
  end

  always @(negedge clk_in) begin
    if (rst_n) begin
      check("ready", 32'(ready_out), 32'(cyc >= busy_until));
      check("regce", 32'(bram_regce), 0);
      if (bram_we) mem[bram_addr] = bram_din;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.done) begin
          check("done_fin", 32'(finished_out), 1);
          check("done_err", 32'(error_out), 32'(mon_e.err));
          check("done_we", 32'(bram_we), 0);
        end else begin
          check("wr_we", 32'(bram_we), 1);
          check("wr_addr", 32'(bram_addr), 32'(mon_e.addr));
          check("wr_din", 32'(bram_din), 32'(mon_e.din));
          check("wr_fin", 32'(finished_out), 0);
        end
      end else begin
        check("idle_we", 32'(bram_we), 0);
        check("idle_fin", 32'(finished_out), 0);
        check("idle_err", 32'(error_out), 0);
      end
    end
  end

  task automatic request(input logic [AW-1:0] a, input logic [XW-1:0] x, input logic [XW-1:0] y);
    logic [2*XW-1:0] xy;
    exp_t e;
    int   h;
    bit   ok;
    xy       = {x, y};
    addr_in  = a;
    x_in     = x;
    y_in     = y;
    valid_in = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_in);
      #1;
      if (ready_out) ok = 1'b1;
    end
    if (!ok) begin
      check("hs_timeout", 0, 1);
      valid_in = 1'b0;
      return;
    end
    h = cyc + 1;
    if (int'(a) < ADDRS) begin
      for (int k = 0; k < 2 * PIECES; k++) begin
        e.done = 1'b0;
        e.err  = 1'b0;
        e.addr = BAW'(int'(a) * 2 * PIECES + k);
        e.din  = xy[k*BW +: BW];
        e.cyc  = h + k;
        sb.push_back(e);
      end
      e.done = 1'b1; e.err = 1'b0; e.addr = '0; e.din = '0; e.cyc = h + 2 * PIECES;
      sb.push_back(e);
      busy_until = h + 2 * PIECES + 1;
    end else begin
      e.done = 1'b1; e.err = 1'b1; e.addr = '0; e.din = '0; e.cyc = h;
      sb.push_back(e);
      busy_until = h + 1;
    end
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk_in);
    check("drain", 32'(sb.size()), 0);
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_slot(input string tag, input int a, input logic [XW-1:0] x, input logic [XW-1:0] y);
    int b;
    b = a * 2 * PIECES;
    check({tag, "_y"}, 32'({mem[b+1], mem[b]}), 32'(y));
    check({tag, "_x"}, 32'({mem[b+3], mem[b+2]}), 32'(x));
  endtask

  logic [XW-1:0] rx [0:7];
  logic [XW-1:0] ry [0:7];

  initial begin
    for (int i = 0; i < (1 << BAW); i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) begin
      rx[i] = 16'($urandom);
      ry[i] = 16'($urandom);
    end

    #12;
    check("rst_ready", 32'(ready_out), 1);
    check("rst_fin", 32'(finished_out), 0);
    check("rst_err", 32'(error_out), 0);
    check("rst_we", 32'(bram_we), 0);
    check("rst_regce", 32'(bram_regce), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_din", 32'(bram_din), 0);
    @(posedge clk_in);
    #2 rst_n = 1'b1;
    @(posedge clk_in);
    #1;

    request(10'd3, 16'hDDCC, 16'hBBAA);
    drain();
    check("m12", 32'(mem[12]), 32'h0AA);
    check("m13", 32'(mem[13]), 32'h0BB);
    check("m14", 32'(mem[14]), 32'h0CC);
    check("m15", 32'(mem[15]), 32'h0DD);

    request(10'd0, rx[0], ry[0]);
    request(10'(ADDRS - 1), rx[1], ry[1]);
    drain();
    check_slot("rt0", 0, rx[0], ry[0]);
    check_slot("rtmax", ADDRS - 1, rx[1], ry[1]);

    request(10'd7, rx[2], ry[2]);
    request(10'd8, rx[3], ry[3]);
    drain();
    check_slot("b2b7", 7, rx[2], ry[2]);
    check_slot("b2b8", 8, rx[3], ry[3]);

    request(10'(ADDRS), rx[4], ry[4]);
    drain();
    request(10'd1023, rx[4], ry[4]);
    request(10'd4, rx[5], ry[5]);
    drain();
    check_slot("after_rej", 4, rx[5], ry[5]);

    request(10'd5, rx[6], ry[6]);
    @(posedge clk_in);
    #1;
    check("k1_we", 32'(bram_we), 1);
    check("k1_addr", 32'(bram_addr), 21);
    #1 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bram_we), 0);
    check("arst_ready", 32'(ready_out), 1);
    check("arst_fin", 32'(finished_out), 0);
    sb.delete();
    busy_until = 0;
    @(posedge clk_in);
    #2 rst_n = 1'b1;
    @(posedge clk_in);
    #1;
    request(10'd6, rx[7], ry[7]);
    drain();
    check_slot("post_rst", 6, rx[7], ry[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
